// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and state encodings shared by the iterative ALU
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/iter_alu_if.sv
// rtl/iter_alu_if.sv - request/response handshake bundle of the iterative ALU
interface iter_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             overflow;
    logic             illegal;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, result_hi, zero, overflow, illegal
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, result_hi, zero, overflow, illegal
    );
endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational AND/OR/ADD/SUB/SLT/NOR datapath with signed overflow
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             legal
);
    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             carry_msb;
    logic             ovf;

    // SLT shares the subtractor so its sign test can be corrected for overflow
    assign sub                = (op == OP_SUB) || (op == OP_SLT);
    assign b_eff              = sub ? ~b : b;
    assign {carry_out, sum}   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    assign carry_msb          = a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1];
    assign ovf                = carry_msb ^ carry_out;

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        legal    = 1'b1;
        case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_NOR: result = ~(a | b);
            OP_ADD, OP_SUB: begin
                result   = sum;
                overflow = ovf;
            end
            OP_SLT: result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
            default: legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/iter_alu.sv
// rtl/iter_alu.sv - handshaked ALU: single-cycle ops via alu_core plus iterative shift-add MUL
module iter_alu
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    iter_alu_if.slave    bus
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   mcand;

    logic [WIDTH-1:0]   core_result;
    logic               core_ovf;
    logic               core_legal;
    logic               is_mul;
    logic               accept;
    logic [WIDTH:0]     partial;
    logic [2*WIDTH-1:0] acc_next;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op       (bus.op),
        .a        (bus.a),
        .b        (bus.b),
        .result   (core_result),
        .overflow (core_ovf),
        .legal    (core_legal)
    );

    assign is_mul       = (MUL_EN != 0) && (bus.op == OP_MUL);
    assign bus.in_ready = rst_n && ((state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready));
    assign accept       = bus.in_valid && bus.in_ready;

    // Add the multiplier into the upper half, then shift the whole accumulator right
    assign partial  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mcand[0] ? mplier : {WIDTH{1'b0}})};
    assign acc_next = {partial, acc[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            acc           <= '0;
            mplier        <= '0;
            mcand         <= '0;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.result_hi <= '0;
            bus.zero      <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.illegal   <= 1'b0;
        end else if (state == ST_BUSY) begin
            if (cnt == CW'(WIDTH)) begin
                state         <= ST_DONE;
                bus.out_valid <= 1'b1;
                bus.result    <= acc[WIDTH-1:0];
                bus.result_hi <= acc[2*WIDTH-1:WIDTH];
                bus.zero      <= (acc[WIDTH-1:0] == '0);
                bus.overflow  <= 1'b0;
                bus.illegal   <= 1'b0;
            end else begin
                acc   <= acc_next;
                mcand <= mcand >> 1;
                cnt   <= cnt + 1'b1;
            end
        end else if (accept) begin
            if (is_mul) begin
                state         <= ST_BUSY;
                cnt           <= '0;
                acc           <= '0;
                mplier        <= bus.b;
                mcand         <= bus.a;
                bus.out_valid <= 1'b0;
            end else begin
                state         <= ST_DONE;
                bus.out_valid <= 1'b1;
                bus.result    <= core_legal ? core_result : '0;
                bus.result_hi <= '0;
                bus.zero      <= !core_legal || (core_result == '0);
                bus.overflow  <= core_legal && core_ovf;
                bus.illegal   <= !core_legal;
            end
        end else if ((state == ST_DONE) && bus.out_ready) begin
            state         <= ST_IDLE;
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_iter_alu.sv
// tb/tb_iter_alu.sv - scoreboard bench for iter_alu (MUL_EN=1 and MUL_EN=0 instances)
module tb_iter_alu;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] r;
        logic [31:0] rh;
        logic        z;
        logic        o;
        logic        il;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t m0_e;
    exp_t m1_e;

    iter_alu_if #(.WIDTH(32)) bus0 ();
    iter_alu_if #(.WIDTH(32)) bus1 ();

    iter_alu #(.WIDTH(32), .MUL_EN(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    iter_alu #(.WIDTH(32), .MUL_EN(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] r, input logic [31:0] rh,
                                input logic z, input logic o, input logic il);
        exp_t e;
        e.r = r; e.rh = rh; e.z = z; e.o = o; e.il = il;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus0.out_valid && bus0.out_ready) begin
            checks++;
            if (q0.size() == 0) begin
                failures++;
                $display("FAIL dut0_unexpected actual=%0h expected=none", bus0.result);
            end else begin
                m0_e = q0.pop_front();
                if ({bus0.result, bus0.result_hi, bus0.zero, bus0.overflow, bus0.illegal} !== m0_e) begin
                    failures++;
                    $display("FAIL dut0_resp actual=%h/%h z%b o%b i%b expected=%h/%h z%b o%b i%b",
                             bus0.result, bus0.result_hi, bus0.zero, bus0.overflow, bus0.illegal,
                             m0_e.r, m0_e.rh, m0_e.z, m0_e.o, m0_e.il);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus1.out_valid && bus1.out_ready) begin
            checks++;
            if (q1.size() == 0) begin
                failures++;
                $display("FAIL dut1_unexpected actual=%0h expected=none", bus1.result);
            end else begin
                m1_e = q1.pop_front();
                if ({bus1.result, bus1.result_hi, bus1.zero, bus1.overflow, bus1.illegal} !== m1_e) begin
                    failures++;
                    $display("FAIL dut1_resp actual=%h/%h z%b o%b i%b expected=%h/%h z%b o%b i%b",
                             bus1.result, bus1.result_hi, bus1.zero, bus1.overflow, bus1.illegal,
                             m1_e.r, m1_e.rh, m1_e.z, m1_e.o, m1_e.il);
                end
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input exp_t e, input bit push);
        bit got;
        got = 1'b0;
        bus0.op = op; bus0.a = a; bus0.b = b; bus0.in_valid = 1'b1;
        if (push) q0.push_back(e);
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = bus0.in_ready;
            @(posedge clk);
            #1;
        end
        if (!got) chk("issue_timeout", 64'd0, 64'd1);
        bus0.in_valid = 1'b0;
    endtask

    task automatic issue1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input exp_t e);
        bus1.op = op; bus1.a = a; bus1.b = b; bus1.in_valid = 1'b1;
        q1.push_back(e);
        @(negedge clk);
        chk("dut1_in_ready", {63'd0, bus1.in_ready}, 64'd1);
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        chk("dut1_single_cycle", {63'd0, bus1.out_valid}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  busy_bad;
        time t0;
        bus0.in_valid = 0; bus0.op = 0; bus0.a = 0; bus0.b = 0; bus0.out_ready = 1;
        bus1.in_valid = 0; bus1.op = 0; bus1.a = 0; bus1.b = 0; bus1.out_ready = 1;

        #12;
        chk("rst_out_valid", {63'd0, bus0.out_valid}, 64'd0);
        chk("rst_in_ready_low", {63'd0, bus0.in_ready}, 64'd0);
        chk("rst_result", {32'd0, bus0.result}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {63'd0, bus0.in_ready}, 64'd1);

        issue(OP_ADD, 32'h7FFFFFFF, 32'h00000001, mk(32'h80000000, 0, 0, 1, 0), 1);
        issue(OP_SLT, 32'h80000000, 32'h00000001, mk(32'h1, 0, 0, 0, 0), 1);
        issue(OP_SUB, 32'h80000000, 32'h00000001, mk(32'h7FFFFFFF, 0, 0, 1, 0), 1);
        issue(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, mk(32'hF000F000, 0, 0, 0, 0), 1);
        issue(OP_OR,  32'hF0F0F0F0, 32'hFF00FF00, mk(32'hFFF0FFF0, 0, 0, 0, 0), 1);
        issue(OP_NOR, 32'h0, 32'h0, mk(32'hFFFFFFFF, 0, 0, 0, 0), 1);
        issue(OP_ADD, 32'hFFFFFFFF, 32'h1, mk(32'h0, 0, 1, 0, 0), 1);
        issue(OP_SUB, 32'h5, 32'h5, mk(32'h0, 0, 1, 0, 0), 1);
        issue(OP_SLT, 32'h1, 32'h80000000, mk(32'h0, 0, 1, 0, 0), 1);
        issue(4'b0101, 32'h1234, 32'h5678, mk(32'h0, 0, 1, 0, 1), 1);

        t0 = $time;
        issue(OP_ADD, 32'h1, 32'h2, mk(32'h3, 0, 0, 0, 0), 1);
        issue(OP_ADD, 32'd10, 32'd20, mk(32'd30, 0, 0, 0, 0), 1);
        issue(OP_ADD, 32'h100, 32'h200, mk(32'h300, 0, 0, 0, 0), 1);
        chk("b2b_cycles", 64'(($time - t0) / 10), 64'd3);

        @(posedge clk); #1;
        bus0.out_ready = 1'b0;
        issue(OP_ADD, 32'h11, 32'h22, mk(32'h33, 0, 0, 0, 0), 1);
        bus0.op = OP_ADD; bus0.a = 32'h40; bus0.b = 32'h2; bus0.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("hold_result", {32'd0, bus0.result}, 64'h33);
            chk("hold_in_ready", {62'd0, bus0.in_ready, bus0.out_valid}, 64'd1);
        end
        q0.push_back(mk(32'h42, 0, 0, 0, 0));
        bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;

        issue(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, mk(32'h1, 32'hFFFFFFFE, 0, 0, 0), 1);
        lat = 0;
        busy_bad = 1'b0;
        for (int k = 1; k <= 100 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (bus0.out_valid) lat = k;
            else if (bus0.in_ready !== 1'b0) busy_bad = 1'b1;
        end
        chk("mul_latency", 64'(lat), 64'd33);
        chk("mul_busy_in_ready", {63'd0, busy_bad}, 64'd0);
        issue(OP_MUL, 32'd3, 32'd5, mk(32'd15, 0, 0, 0, 0), 1);
        issue(OP_MUL, 32'h10000, 32'h10000, mk(32'h0, 32'h1, 1, 0, 0), 1);

        issue(OP_ADD, 32'h1, 32'h2, mk(32'h3, 0, 0, 0, 0), 1);
        issue(OP_MUL, 32'h7, 32'h9, mk(0, 0, 0, 0, 0), 0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, bus0.out_valid}, 64'd0);
        chk("midrst_outputs", {bus0.result[31:0], bus0.result_hi[28:0], bus0.zero, bus0.overflow, bus0.illegal}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", {63'd0, bus0.in_ready}, 64'd1);
        repeat (40) @(posedge clk);
        #1;
        chk("midrst_no_stale", {62'd0, bus0.out_valid, bus0.in_ready}, 64'd1);

        issue1(OP_ADD, 32'd2, 32'd3, mk(32'd5, 0, 0, 0, 0));
        issue1(OP_MUL, 32'd3, 32'd5, mk(32'h0, 0, 1, 0, 1));
        issue1(4'b0101, 32'd3, 32'd5, mk(32'h0, 0, 1, 0, 1));

        repeat (5) @(posedge clk);
        #1;
        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
